// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Purpose  : Shared core-wide widths, constants and fetch entry type.
//  Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

    // One prefetch queue slot: the fetch address and the word returned for it
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous show-ahead FIFO with a registered head word and a
//             flush input. The head changes only on push-into-empty or pop.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_head;
    assign w_pop  = pop && !empty && !flush;
    assign w_push = push && (!full || w_pop) && !flush;

    // Storage array: written at the tail, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Registered head: next stored entry on pop, or incoming word when it becomes the only entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
        end else if (w_pop && (r_count > CW'(1))) begin
            r_head <= r_mem[next_ptr(r_rd_ptr)];
        end else if (w_push && (empty || w_pop)) begin
            r_head <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch front end. Owns the PC, issues in-order
//             requests to a variable-latency memory under a credit limit,
//             buffers responses in a prefetch queue and handles redirects by
//             flushing the queue and dropping in-flight responses.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
);

    import core_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int QW = XLEN + ILEN;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   w_outstanding_next;
    logic [CW-1:0]   w_q_count;
    logic [CW-1:0]   w_pf_count;
    logic [XLEN-1:0] w_rsp_pc;
    logic [QW-1:0]   w_q_head;
    logic            w_req_fire;
    logic            w_rsp_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_q_empty;
    logic            w_q_full;
    logic            w_pf_full;
    logic            w_pf_empty;
    logic            w_unused;

    // Credit rule: queued plus in-flight fetches never exceed DEPTH, so a push never meets a full queue
    assign imem_req_valid = !rst && !redirect_valid &&
                            ((int'(w_q_count) + int'(r_outstanding)) < DEPTH);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses with nothing in flight (e.g. stale ones after reset) are ignored
    assign w_rsp_accept = imem_rsp_valid && (r_outstanding != '0);
    assign w_push       = w_rsp_accept && (r_drop == '0) && !redirect_valid;
    assign w_pop        = inst_valid && inst_ready && !redirect_valid;

    assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_accept);

    assign inst_valid = !w_q_empty;
    assign inst       = w_q_head[ILEN-1:0];
    assign inst_pc    = w_q_head[QW-1:ILEN];

    assign w_unused = ^{w_q_full, w_pf_full, w_pf_empty, w_pf_count};

    // PC: redirect target wins, otherwise advance by one word per accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_req_fire) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    // In-flight and drop counters; a redirect marks everything still in flight as stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                r_drop <= w_outstanding_next;
            end else if (w_rsp_accept && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    // Address of each in-flight request, popped as its response returns (stale or not)
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_req_fire),
        .push_data (r_pc),
        .pop       (w_rsp_accept),
        .flush     (1'b0),
        .head      (w_rsp_pc),
        .full      (w_pf_full),
        .empty     (w_pf_empty),
        .count     (w_pf_count)
    );

    // Prefetch queue of {pc, instruction}, cleared on redirect
    fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_prefetch_q (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({w_rsp_pc, imem_rsp_data}),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_q_head),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .count     (w_q_count)
    );

`ifndef SYNTHESIS
    // A response with nothing in flight is a memory-side protocol error
    a_rsp_has_request : assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (r_outstanding != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit with an in-order memory
//             model and an epoch-tagged behavioural reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        req_valid2;
    logic [31:0] req_addr2;
    logic        inst_valid2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = '0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redir), .redirect_pc(redir_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid2), .imem_req_ready(req_ready), .imem_req_addr(req_addr2),
        .imem_rsp_valid(zero_bit), .imem_rsp_data(zero_word),
        .redirect_valid(zero_bit), .redirect_pc(zero_word),
        .inst_valid(inst_valid2), .inst_ready(zero_bit), .inst(inst2), .inst_pc(inst_pc2)
    );

    // Reference model: memory requests tagged with the redirect epoch they were issued in
    typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;
    mreq_t       mem_q[$];
    logic [31:0] mq[$];
    int          epoch = 0;
    int          cyc = 0;
    logic [31:0] req_pc = '0;

    int rr_pct = 100, ir_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = '0;

    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];
    bit          last_req_valid, last_inst_valid, last_rsp;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // One clock: drive inputs at negedge, compare against model, then advance model over the posedge
    task automatic step();
        bit          exp_rv, exp_iv, fire, pop, rsp;
        logic [31:0] r_addr;
        int          r_ep;
        @(negedge clk);
        rsp        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rsp_valid  = rsp;
        rsp_data   = rsp ? memword(mem_q[0].addr) : $urandom;
        req_ready  = ($urandom_range(99) < rr_pct);
        inst_ready = ($urandom_range(99) < ir_pct);
        redir      = force_redir || ($urandom_range(99) < redir_pct);
        redir_pc   = force_redir ? force_pc : ($urandom & 32'h0000_FFFC);
        force_redir = 1'b0;
        #1;
        exp_rv = !redir && ((mq.size() + mem_q.size()) < DEPTH);
        exp_iv = (mq.size() != 0);
        chk("req_valid", req_valid, exp_rv);
        if (exp_rv) chk("req_addr", req_addr, req_pc);
        chk("inst_valid", inst_valid, exp_iv);
        if (exp_iv) begin
            chk("inst_pc", inst_pc, mq[0]);
            chk("inst", inst, memword(mq[0]));
        end
        if (req_valid && req_ready) begin
            acc_addr.push_back(req_addr);
            acc_cyc.push_back(cyc);
        end
        if (inst_valid && inst_ready && !redir) begin
            pop_pc.push_back(inst_pc);
            pop_cyc.push_back(cyc);
        end
        last_req_valid  = req_valid;
        last_inst_valid = inst_valid;
        last_rsp        = rsp;
        fire = exp_rv && req_ready;
        pop  = exp_iv && inst_ready;
        r_addr = '0;
        r_ep   = -1;
        if (rsp) begin
            r_addr = mem_q[0].addr;
            r_ep   = mem_q[0].ep;
            void'(mem_q.pop_front());
        end
        if (redir) begin
            mq.delete();
            epoch++;
            req_pc = redir_pc;
        end else begin
            if (pop) void'(mq.pop_front());
            if (rsp && (r_ep == epoch)) mq.push_back(r_addr);
            if (fire) begin
                mem_q.push_back('{req_pc, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
                req_pc = req_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    // Asynchronous reset mid-stream; memory side shares the reset so its queue is dropped too
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        rsp_valid = 1'b0; redir = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
        #1;
        chk("rst_req_valid", req_valid, 32'd0);
        chk("rst_inst_valid", inst_valid, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        repeat (2) @(posedge clk);
        mq.delete();
        mem_q.delete();
        epoch++;
        req_pc = 32'h0;
        acc_addr.delete(); acc_cyc.delete(); pop_pc.delete(); pop_cyc.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int mark, bad;

        // Reset, stream with 1-cycle memory, and wrap on the second instance
        do_reset();
        rr_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
        step();
        chk("wrap_first_valid", req_valid2, 32'd1);
        chk("wrap_first_addr", req_addr2, 32'hFFFF_FFFC);
        step();
        chk("wrap_second_addr", req_addr2, 32'h0000_0000);
        repeat (8) step();
        chk("first_req_addr", acc_addr[0], 32'h0);
        chk("stream_pop0", pop_pc[0], 32'h0);
        chk("stream_pop1", pop_pc[1], 32'h4);
        chk("stream_pop2", pop_pc[2], 32'h8);
        chk("stream_pop3", pop_pc[3], 32'hC);
        chk("stream_consecutive", pop_cyc[3] - pop_cyc[0], 32'd3);
        chk("stream_latency", pop_cyc[0] - acc_cyc[0], 32'd2);

        // Backpressure: consumer stalled, credit caps issue at DEPTH
        do_reset();
        ir_pct = 0;
        repeat (10) step();
        chk("bp_accepts", acc_addr.size(), 32'd4);
        chk("bp_req_valid_low", last_req_valid, 32'd0);
        chk("bp_head_pc", inst_pc, 32'h0);
        ir_pct = 100;
        repeat (20) step();
        bad = 0;
        foreach (pop_pc[i]) if (pop_pc[i] != 32'(4 * i)) bad++;
        chk("bp_sequence_errors", bad, 32'd0);
        chk("bp_enough_pops", pop_pc.size() >= 8, 32'd1);

        // Redirect with two requests outstanding on a 3-cycle memory
        do_reset();
        lat_min = 3; lat_max = 3;
        repeat (2) step();
        rr_pct = 0;
        force_redir = 1'b1; force_pc = 32'h100;
        step();
        rr_pct = 100;
        repeat (15) step();
        chk("redir_acc0", acc_addr[0], 32'h0);
        chk("redir_acc1", acc_addr[1], 32'h4);
        chk("redir_next_req", acc_addr[2], 32'h100);
        chk("redir_first_pop", pop_pc[0], 32'h100);

        // Redirect coincident with an arriving response and a pop
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (6) step();
        force_redir = 1'b1; force_pc = 32'h200;
        step();
        chk("coinc_no_req", last_req_valid, 32'd0);
        chk("coinc_rsp_present", last_rsp, 32'd1);
        chk("coinc_head_valid", last_inst_valid, 32'd1);
        mark = pop_pc.size();
        step();
        chk("coinc_cleared", last_inst_valid, 32'd0);
        repeat (10) step();
        chk("coinc_first_pop", pop_pc[mark], 32'h200);

        // Randomized traffic with variable latency, stalls and redirects
        for (int blk = 0; blk < 8; blk++) begin
            if (blk == 4) do_reset();
            rr_pct    = 40 + int'($urandom_range(60));
            ir_pct    = 30 + int'($urandom_range(70));
            lat_min   = 1;
            lat_max   = 1 + int'($urandom_range(5));
            redir_pct = int'($urandom_range(6));
            repeat (500) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
